// File: rtl/branch_pc_unit.sv
// Program counter and branch/jump target unit: selects the next PC, counts
// retired PC advances and halts with the faulting target on a misaligned fetch.
module branch_pc_unit #(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic             jal_i,
  input  logic             jalr_i,
  input  logic [2:0]       funct3_i,
  input  logic [WIDTH-1:0] imm_i,
  input  logic [WIDTH-1:0] rs1_i,
  input  logic             greater_s_i,
  input  logic             equal_s_i,
  input  logic             lesser_s_i,
  input  logic             greater_u_i,
  input  logic             equal_u_i,
  input  logic             lesser_u_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc_plus4_o,
  output logic             taken_o,
  output logic             illegal_o,
  output logic             halted_o,
  output logic [WIDTH-1:0] trap_addr_o,
  output logic [31:0]      instret_o
);

  typedef enum logic {
    S_RUN,
    S_HALT
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] trap_addr_q, trap_addr_d;
  logic [31:0]      instret_q, instret_d;

  logic             cond;
  logic [WIDTH-1:0] jalr_sum;
  logic [WIDTH-1:0] next_pc;

  always_comb begin
    cond = 1'b0;
    unique case (funct3_i)
      3'b000:  cond = equal_s_i;
      3'b001:  cond = !equal_s_i;
      3'b100:  cond = lesser_s_i;
      3'b101:  cond = greater_s_i | equal_s_i;
      3'b110:  cond = lesser_u_i;
      3'b111:  cond = greater_u_i | equal_u_i;
      default: cond = 1'b0;
    endcase
  end

  assign illegal_o  = branch_i && (funct3_i[2:1] == 2'b01);
  assign pc_plus4_o = pc_q + WIDTH'(4);
  assign jalr_sum   = rs1_i + imm_i;

  always_comb begin
    next_pc = pc_plus4_o;
    taken_o = 1'b0;
    if (jalr_i) begin
      next_pc = {jalr_sum[WIDTH-1:1], 1'b0};
      taken_o = 1'b1;
    end else if (jal_i || (branch_i && cond)) begin
      next_pc = pc_q + imm_i;
      taken_o = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    trap_addr_d = trap_addr_q;
    instret_d   = instret_q;
    if (state_q == S_RUN && !stall_i) begin
      if (next_pc[1:0] != 2'b00) begin
        state_d     = S_HALT;
        trap_addr_d = next_pc;
      end else begin
        pc_d      = next_pc;
        instret_d = instret_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_RUN;
      pc_q        <= RESET_ADDR;
      trap_addr_q <= '0;
      instret_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      trap_addr_q <= trap_addr_d;
      instret_q   <= instret_d;
    end
  end

  assign pc_o        = pc_q;
  assign halted_o    = (state_q == S_HALT);
  assign trap_addr_o = trap_addr_q;
  assign instret_o   = instret_q;

endmodule
